// File: rtl/zcash_resp_arbiter.sv
// Packet-level round-robin arbiter that merges N_SRC response streams onto one
// registered AXI-stream output; a granted source holds the lock until its eop beat.
module zcash_resp_arbiter #(
    parameter int N_SRC    = 2,
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_SRC-1:0]              i_val,
    input  logic [N_SRC*DAT_BYTS*8-1:0]   i_dat,
    input  logic [N_SRC*CTL_BITS-1:0]     i_ctl,
    input  logic [N_SRC*MOD_BITS-1:0]     i_mod,
    input  logic [N_SRC-1:0]              i_sop,
    input  logic [N_SRC-1:0]              i_eop,
    output logic [N_SRC-1:0]              o_rdy,
    output logic                          o_val,
    output logic [DAT_BYTS*8-1:0]         o_dat,
    output logic [CTL_BITS-1:0]           o_ctl,
    output logic [MOD_BITS-1:0]           o_mod,
    output logic                          o_sop,
    output logic                          o_eop,
    input  logic                          i_rdy,
    output logic [N_SRC-1:0]              o_grant
);

    localparam int DW = DAT_BYTS * 8;
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic [DW-1:0]       dat;
        logic [CTL_BITS-1:0] ctl;
        logic [MOD_BITS-1:0] mod;
        logic                sop;
        logic                eop;
    } beat_t;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    beat_t         src [N_SRC];
    beat_t         sel;
    logic          out_free;
    logic          xfer;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign src[k] = {i_dat[k*DW +: DW], i_ctl[k*CTL_BITS +: CTL_BITS],
                         i_mod[k*MOD_BITS +: MOD_BITS], i_sop[k], i_eop[k]};
    end

    // While locked, last is the granted source index.
    assign sel      = src[last];
    assign out_free = !o_val || i_rdy;
    assign xfer     = (state == LOCK) && i_val[last] && out_free;
    assign o_rdy    = o_grant & {N_SRC{out_free}};

    // Scan from last+1 with wrap; iterating downward lets the nearest requester win.
    always_comb begin
        logic [IW-1:0] idx;
        win = '0;
        idx = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % N_SRC);
            if (i_val[idx]) win = idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            last    <= IW'(N_SRC - 1);
            o_grant <= '0;
            o_val   <= 1'b0;
            o_dat   <= '0;
            o_ctl   <= '0;
            o_mod   <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|i_val) begin
                    state   <= LOCK;
                    last    <= win;
                    o_grant <= N_SRC'(1) << win;
                end
                LOCK: if (xfer && sel.eop) begin
                    state   <= IDLE;
                    o_grant <= '0;
                end
                default: state <= IDLE;
            endcase
            if (out_free) begin
                o_val <= xfer;
                if (xfer) begin
                    o_dat <= sel.dat;
                    o_ctl <= sel.ctl;
                    o_mod <= sel.mod;
                    o_sop <= sel.sop;
                    o_eop <= sel.eop;
                end
            end
        end
    end

endmodule

// File: tb/tb_zcash_resp_arbiter.sv
// Bench for zcash_resp_arbiter: directed latency/reset cases plus queue-based
// traffic runs scored per source, with grant order and idle gaps logged.
module tb_zcash_resp_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int CB = 8;
    localparam int MB = 3;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_val;
    logic [N*DW-1:0]   i_dat;
    logic [N*CB-1:0]   i_ctl;
    logic [N*MB-1:0]   i_mod;
    logic [N-1:0]      i_sop, i_eop;
    logic [N-1:0]      o_rdy;
    logic              o_val;
    logic [DW-1:0]     o_dat;
    logic [CB-1:0]     o_ctl;
    logic [MB-1:0]     o_mod;
    logic              o_sop, o_eop;
    logic              i_rdy;
    logic [N-1:0]      o_grant;

    always #5 i_clk = ~i_clk;

    zcash_resp_arbiter #(.N_SRC(N), .DAT_BYTS(8), .CTL_BITS(CB), .MOD_BITS(MB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_dat(i_dat), .i_ctl(i_ctl),
        .i_mod(i_mod), .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy), .o_val(o_val),
        .o_dat(o_dat), .o_ctl(o_ctl), .o_mod(o_mod), .o_sop(o_sop), .o_eop(o_eop),
        .i_rdy(i_rdy), .o_grant(o_grant)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [CB-1:0] ctl;
        logic [MB-1:0] mod;
        logic          sop;
        logic          eop;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    pkt_id = 0;
    beat_t src_q [N][$];
    beat_t sb_q  [N][$];
    int    grant_log[$];
    int    gap_log[$];

    task automatic set_src(input int s, input beat_t b, input logic v);
        i_val[s]            = v;
        i_dat[s*DW +: DW]   = v ? b.dat : '0;
        i_ctl[s*CB +: CB]   = v ? b.ctl : '0;
        i_mod[s*MB +: MB]   = v ? b.mod : '0;
        i_sop[s]            = v ? b.sop : 1'b0;
        i_eop[s]            = v ? b.eop : 1'b0;
    endtask

    task automatic clear_inputs();
        i_val = '0; i_dat = '0; i_ctl = '0; i_mod = '0; i_sop = '0; i_eop = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rdy = 1'b1;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            sb_q[s].delete();
        end
        grant_log.delete();
        gap_log.delete();
    endtask

    // Source id lives in the top data byte so the scoreboard can route output beats.
    task automatic add_pkt(input int s, input int len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.dat = {8'(s), 8'(pkt_id), 16'(b), 32'($urandom())};
            x.ctl = 8'($urandom());
            x.mod = 3'($urandom());
            x.sop = (b == 0);
            x.eop = (b == len - 1);
            src_q[s].push_back(x);
        end
        pkt_id++;
    endtask

    // Plays src_q through the DUT, scoring outputs against sb_q.
    // rdy_mode: 0 always ready, 1 random, 2 low for [lo_start, lo_start+lo_len).
    task automatic run_traffic(input int rdy_mode, input int lo_start, input int lo_len,
                               input int stall_src, input int stall_after, input int stall_len,
                               input bit rand_gap, input int budget, output int cycles);
        bit                  hold[N];
        int                  sent[N];
        logic [N-1:0]        xf;
        logic [N-1:0]        prev_grant;
        logic [DW+CB+MB+1:0] snap;
        bit                  snap_v, in_pkt, done, stalled;
        int                  cur, zero_run, stall_cnt, s_out, cyc;
        beat_t               exp_b;
        for (int s = 0; s < N; s++) begin hold[s] = 0; sent[s] = 0; end
        xf = '0; prev_grant = '0; snap = '0; snap_v = 0; in_pkt = 0; done = 0;
        cur = 0; zero_run = 0; stall_cnt = 0; cyc = 0;
        for (cyc = 0; cyc < budget; cyc++) begin
            @(posedge i_clk); #1;
            for (int s = 0; s < N; s++) if (xf[s]) begin
                sb_q[s].push_back(src_q[s].pop_front());
                hold[s] = 0;
                sent[s]++;
            end
            done = !o_val;
            for (int s = 0; s < N; s++)
                if (src_q[s].size() != 0 || sb_q[s].size() != 0) done = 0;
            if (done) break;
            stalled = (stall_src >= 0) && (sent[stall_src] == stall_after) &&
                      (stall_cnt < stall_len) && (src_q[stall_src].size() != 0);
            if (stalled) stall_cnt++;
            for (int s = 0; s < N; s++) begin
                if (src_q[s].size() != 0 && !hold[s] && !(stalled && s == stall_src))
                    hold[s] = rand_gap ? ($urandom_range(3) != 0) : 1'b1;
                set_src(s, hold[s] ? src_q[s][0] : beat_t'(0), hold[s]);
            end
            case (rdy_mode)
                0:       i_rdy = 1'b1;
                1:       i_rdy = ($urandom_range(3) != 0);
                default: i_rdy = !(cyc >= lo_start && cyc < lo_start + lo_len);
            endcase
            @(negedge i_clk);
            xf = i_val & o_rdy;
            checks++;
            if ($countones(o_grant) > 1 || (o_rdy & ~o_grant) != 0) begin
                errors++;
                $display("FAIL grant_rdy_onehot: grant=%b rdy=%b", o_grant, o_rdy);
            end
            checks++;
            if (o_val && !i_rdy && o_rdy != 0) begin
                errors++;
                $display("FAIL rdy_under_backpressure: rdy=%b required 0", o_rdy);
            end
            if (snap_v) begin
                checks++;
                if (!o_val || {o_dat, o_ctl, o_mod, o_sop, o_eop} !== snap) begin
                    errors++;
                    $display("FAIL hold_stable: val=%b got %h required %h", o_val,
                             {o_dat, o_ctl, o_mod, o_sop, o_eop}, snap);
                end
            end
            snap_v = o_val && !i_rdy;
            snap   = {o_dat, o_ctl, o_mod, o_sop, o_eop};
            if (stalled) begin
                checks++;
                if (o_grant !== N'(1) << stall_src) begin
                    errors++;
                    $display("FAIL lock_during_stall: grant=%b required %b", o_grant,
                             N'(1) << stall_src);
                end
            end
            if (o_val && i_rdy) begin
                s_out = int'(o_dat[63:56]);
                checks++;
                if (s_out >= N || sb_q[s_out].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: dat=%h", o_dat);
                end else begin
                    exp_b = sb_q[s_out].pop_front();
                    if ({o_dat, o_ctl, o_mod, o_sop, o_eop} !== exp_b) begin
                        errors++;
                        $display("FAIL beat_data: got %h required %h",
                                 {o_dat, o_ctl, o_mod, o_sop, o_eop}, exp_b);
                    end
                    checks++;
                    if (in_pkt && s_out != cur) begin
                        errors++;
                        $display("FAIL interleave: got src %0d required src %0d", s_out, cur);
                    end
                    in_pkt = !o_eop;
                    cur    = s_out;
                end
            end
            if (o_grant != 0 && o_grant != prev_grant) begin
                grant_log.push_back($clog2(o_grant));
                gap_log.push_back(zero_run);
            end
            zero_run   = (o_grant == 0) ? zero_run + 1 : 0;
            prev_grant = o_grant;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL traffic_timeout: ran %0d cycles without draining", budget);
        end
        clear_inputs();
        i_rdy  = 1'b1;
        cycles = cyc;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_rdy = 1'b1; i_val = '1; i_dat = '1; i_sop = '1; i_eop = '1;
        i_ctl = '1; i_mod = '1;
        @(posedge i_clk); @(negedge i_clk);
        checks++;
        if ({o_val, o_rdy, o_grant} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: val=%b rdy=%b grant=%b required 0", o_val, o_rdy, o_grant);
        end
        checks++;
        if ({o_dat, o_ctl, o_mod, o_sop, o_eop} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h required 0", {o_dat, o_ctl, o_mod, o_sop, o_eop});
        end
        do_reset();
    endtask

    task automatic test_single_packet();
        beat_t b;
        logic [DW-1:0] exp_dat [3];
        exp_dat[0] = 64'h11; exp_dat[1] = 64'h22; exp_dat[2] = 64'h33;
        do_reset();
        b = '0; b.dat = exp_dat[0]; b.ctl = 8'h5A; b.sop = 1'b1;
        @(posedge i_clk); #1 set_src(0, b, 1'b1);
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00 || o_val !== 1'b0) begin
            errors++;
            $display("FAIL single_t0: grant=%b val=%b required 00/0", o_grant, o_val);
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01 || o_rdy !== 2'b01 || o_val !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: grant=%b rdy=%b val=%b required 01/01/0",
                     o_grant, o_rdy, o_val);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            if (k < 2) begin
                b = '0; b.dat = exp_dat[k+1]; b.ctl = 8'h5A; b.eop = (k == 1);
                set_src(0, b, 1'b1);
            end else clear_inputs();
            @(negedge i_clk);
            checks++;
            if (o_val !== 1'b1 || o_dat !== exp_dat[k] || o_sop !== (k == 0) ||
                o_eop !== (k == 2) || o_ctl !== 8'h5A) begin
                errors++;
                $display("FAIL single_beat%0d: val=%b dat=%h sop=%b eop=%b required 1/%h/%b/%b",
                         k, o_val, o_dat, o_sop, o_eop, exp_dat[k], k == 0, k == 2);
            end
        end
        checks++;
        if (o_grant !== 2'b00) begin
            errors++;
            $display("FAIL single_idle_after_eop: grant=%b required 00", o_grant);
        end
        @(posedge i_clk); @(negedge i_clk);
        checks++;
        if (o_val !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: val=%b required 0", o_val);
        end
    endtask

    task automatic test_two_sources();
        int cyc;
        do_reset();
        add_pkt(0, 2); add_pkt(1, 2);
        run_traffic(0, 0, 0, -1, 0, 0, 0, 200, cyc);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++;
            $display("FAIL two_src_order: got %p required '{0,1}", grant_log);
        end
        checks++;
        if (gap_log.size() != 2 || gap_log[1] != 1) begin
            errors++;
            $display("FAIL two_src_gap: got %p required second gap 1", gap_log);
        end
    endtask

    task automatic test_round_robin();
        int cyc, n0, n1;
        do_reset();
        for (int p = 0; p < 4; p++) begin add_pkt(0, 1); add_pkt(1, 1); end
        run_traffic(0, 0, 0, -1, 0, 0, 0, 300, cyc);
        n0 = 0; n1 = 0;
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d grants required 8", grant_log.size());
        end
        foreach (grant_log[i]) begin
            if (grant_log[i] == 0) n0++; else n1++;
            checks++;
            if (grant_log[i] != i % 2 || gap_log[i] != 1) begin
                errors++;
                $display("FAIL rr_order[%0d]: src %0d gap %0d required src %0d gap 1",
                         i, grant_log[i], gap_log[i], i % 2);
            end
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin
            errors++;
            $display("FAIL rr_balance: got %0d/%0d required 4/4", n0, n1);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        add_pkt(0, 6);
        run_traffic(2, 3, 5, -1, 0, 0, 0, 200, cyc);
        // 1 arbitration cycle + 6 beats + 1 drain cycle, stretched by the stall window.
        checks++;
        if (cyc != 2 + 6 + 5) begin
            errors++;
            $display("FAIL bp_throughput: got %0d cycles required %0d", cyc, 13);
        end
    endtask

    task automatic test_source_stall();
        int cyc;
        do_reset();
        add_pkt(0, 3); add_pkt(1, 2);
        run_traffic(0, 0, 0, 0, 1, 10, 0, 300, cyc);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++;
            $display("FAIL stall_order: got %p required '{0,1}", grant_log);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t b;
        do_reset();
        b = '0; b.dat = 64'hA1; b.sop = 1'b1;
        @(posedge i_clk); #1 set_src(0, b, 1'b1);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        b = '0; b.dat = 64'hA2;
        set_src(0, b, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        clear_inputs();
        @(negedge i_clk);
        checks++;
        if (o_val !== 1'b0 || o_grant !== 2'b00 || o_rdy !== 2'b00 || o_dat !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: val=%b grant=%b rdy=%b dat=%h required all 0",
                     o_val, o_grant, o_rdy, o_dat);
        end
        b = '0; b.dat = 64'hB0; b.sop = 1'b1; b.eop = 1'b1;
        @(posedge i_clk); #1;
        set_src(0, b, 1'b1);
        b.dat = 64'hB1;
        set_src(1, b, 1'b1);
        @(posedge i_clk); @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_regrant: grant=%b required 01", o_grant);
        end
        do_reset();
    endtask

    task automatic test_random_traffic();
        int cyc, cnt[N];
        do_reset();
        for (int p = 0; p < 6; p++)
            for (int s = 0; s < N; s++) add_pkt(s, $urandom_range(4, 1));
        run_traffic(1, 0, 0, -1, 0, 0, 1, 3000, cyc);
        for (int s = 0; s < N; s++) cnt[s] = 0;
        foreach (grant_log[i]) cnt[grant_log[i]]++;
        for (int s = 0; s < N; s++) begin
            checks++;
            if (cnt[s] != 6) begin
                errors++;
                $display("FAIL rand_grants_src%0d: got %0d required 6", s, cnt[s]);
            end
        end
    endtask

    initial begin
        clear_inputs();
        i_rdy = 1'b1;
        i_rst = 1'b0;
        test_reset();
        test_single_packet();
        test_two_sources();
        test_round_robin();
        test_backpressure();
        test_source_stall();
        test_reset_mid_packet();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/zcash_resp_arbiter.md
Name: zcash_resp_arbiter

Overview:
Packet-level round-robin arbiter that shares the single command-interface return stream (toward the tx width-change FIFO) between N response sources, e.g. the equihash result and secp256k1 result streams.
- Once a source is granted, it is locked until its end-of-packet beat has transferred, so packets are never interleaved.
- The output is one registered AXI-stream stage that honours backpressure.

Parameters:
N_SRC, 2, number of requesting sources (2..8)
DAT_BYTS, 8, data bytes per beat
CTL_BITS, 8, sideband control bits per beat
MOD_BITS, 3, width of the mod field; must equal $clog2(DAT_BYTS)

Ports:
i_clk  in  1  core/interface clock
i_rst  in  1  synchronous, active-high reset
i_val  in  N_SRC  per-source beat valid
i_dat  in  N_SRC*DAT_BYTS*8  per-source data; source k occupies slice k
i_ctl  in  N_SRC*CTL_BITS  per-source control sideband
i_mod  in  N_SRC*MOD_BITS  per-source valid-byte count; 0 means all bytes valid
i_sop  in  N_SRC  per-source start of packet
i_eop  in  N_SRC  per-source end of packet
o_rdy  out  N_SRC  per-source ready
o_val  out  1  output beat valid
o_dat  out  DAT_BYTS*8  output data
o_ctl  out  CTL_BITS  output control
o_mod  out  MOD_BITS  output mod
o_sop  out  1  output start of packet
o_eop  out  1  output end of packet
i_rdy  in  1  downstream ready
o_grant  out  N_SRC  one-hot index of the currently locked source; 0 when idle

Behaviour:
- Reset: the following take these values on the first i_clk edge with i_rst=1:
  - o_val=0, o_rdy=0, o_grant=0
  - o_dat/o_ctl/o_mod/o_sop/o_eop=0
  - state=IDLE
  - last grant pointer = N_SRC-1, so source 0 wins first.
- A beat transfers on a side when val&&rdy at a clock edge.
- Output register:
  - Can accept when out_free = !o_val || i_rdy.
  - On accept it loads the selected source's fields and sets o_val=1.
  - If i_rdy=1 and nothing is loaded, o_val clears next cycle.
  - While o_val=1 and i_rdy=0, all o_* fields hold stable.
- IDLE state:
  - o_rdy=0 and o_grant=0.
  - If any i_val bit is 1, the winner is the first set bit searching from last+1 upward, with wrap-around modulo N_SRC.
  - Next cycle: state=LOCK, o_grant=onehot(winner), last=winner.
  - If no i_val bit is set, stay in IDLE.
- LOCK state (granted source g):
  - o_rdy[g] = out_free; o_rdy of every other source = 0.
  - Each transferred beat of g loads the output register.
  - When a beat with i_eop[g]=1 transfers, next state=IDLE and o_grant=0.
  - i_val[g]=0 mid-packet: the lock is held indefinitely. There is no timeout.
- Latency and throughput:
  - i_val rises at cycle t (IDLE, out register free): grant at t+1, beat accepted at t+1, o_val=1 at t+2.
  - Within a packet: 1 beat/cycle when i_rdy=1.
  - Between packets: exactly 1 idle arbitration cycle.
- Single-beat packets (sop&&eop in the same beat) are legal: LOCK lasts one transfer cycle.
- No sop check: sop/eop/mod/ctl pass through unmodified. Only eop is interpreted.
- Requests from other sources that arrive while locked wait with no loss. Their i_val stays asserted per AXI rules.
- Fairness: a source that was just served has lowest priority at the next arbitration. With all N_SRC sources continuously requesting, grants cycle 0,1,..,N_SRC-1,0.
- Reset mid-packet:
  - The partial packet is dropped and the output is cleared.
  - Remaining beats of the interrupted source are accepted only after a new grant, so upstream must also be reset. Upstream shares the same usr_rst.

Test Plan:
1. Reset, then only source 0 sends a 3-beat packet with dat=0x11,0x22,0x33 and eop on beat 3; i_rdy=1 -> o_grant=01 at t+1; o_val beats at t+2..t+4 with identical data; sop on the first beat only, eop on the last; state back to IDLE at t+4.
2. Both sources assert i_val in the same cycle, each with a 2-beat packet -> source 0 output fully, then one idle cycle, then source 1; no interleaving of beats.
3. Both sources request continuously with 1-beat packets for 8 packets -> grant order 0,1,0,1,...; each source receives exactly 4 grants.
4. i_rdy held 0 for 5 cycles mid-packet -> o_* stable throughout, o_rdy[g]=0 while o_val=1, no beat lost or duplicated; streaming resumes 1 beat/cycle when i_rdy returns to 1.
5. Granted source deasserts i_val for 10 cycles mid-packet while the other source requests -> o_grant unchanged, no beats from the other source; the other source is served only after the eop beat.
6. i_rst asserted during beat 2 of a 4-beat packet -> next cycle o_val=0, o_grant=0, o_rdy=0; a fresh packet after reset is granted to source 0 first.
